snn_psum_neuron: RTL

Clocked neuron/accumulation stage directly downstream of the convolution PEs. It receives 34-bit partial-sum packets (type `2'b10`) from the three PEs and combines the three psums belonging to each output row. It then updates that row's membrane potential with integrate-and-fire semantics and emits one 34-bit spike packet per row per timestep toward the output collector.

---
 rtl/snn_psum_neuron_if.sv | 24 ++
 rtl/snn_psum_neuron.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/snn_psum_neuron_if.sv
// Packet stream bundle for the psum neuron: psum input channel, spike output
// channel and the two status pulses.
interface snn_psum_neuron_if #(
  parameter int WIDTH = 34
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             timestep_done;
  logic             err_drop;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, timestep_done, err_drop
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, timestep_done, err_drop
  );
endinterface

// File: rtl/snn_psum_neuron.sv
// Integrate-and-fire neuron stage: merges three PE psums per output row,
// updates that row's membrane potential and emits one spike packet per row.
module snn_psum_neuron #(
  parameter int         WIDTH     = 34,
  parameter int         PSUM_W    = 8,
  parameter int         VMEM_W    = 12,
  parameter int         THRESHOLD = 64,
  parameter int         OUT_ROWS  = 3,
  parameter int         TIMESTEPS = 10,
  parameter logic [3:0] PE1_ADDR  = 4'b0010,
  parameter logic [3:0] PE2_ADDR  = 4'b0110,
  parameter logic [3:0] PE3_ADDR  = 4'b1010,
  parameter logic [3:0] MY_ADDR   = 4'b0001,
  parameter logic [3:0] DEST_ADDR = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rst,
  snn_psum_neuron_if.slave      bus
);

  localparam int RW = $clog2(OUT_ROWS);
  localparam int TW = 8;
  localparam logic [VMEM_W-1:0] THR = VMEM_W'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  logic [VMEM_W-1:0] r_vmem     [OUT_ROWS];
  logic [9:0]        r_acc      [OUT_ROWS];
  logic [2:0]        r_mask     [OUT_ROWS];
  logic [RW-1:0]     r_rcnt     [3];
  logic [RW-1:0]     r_fire_ptr;
  logic [TW-1:0]     r_ts;
  state_t            r_state;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_ts_done;
  logic              r_err_drop;

  logic [3:0]        w_src;
  logic [1:0]        w_type;
  logic [PSUM_W-1:0] w_psum;
  logic [2:0]        w_pe_hit;
  logic [1:0]        w_pe;
  logic              w_legal;
  logic [RW-1:0]     w_row;
  logic              w_stall;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_accept;
  logic              w_full;
  logic              w_last_row;
  logic              w_last_ts;
  logic [VMEM_W:0]   w_sum;
  logic [VMEM_W-1:0] w_sat;
  logic              w_spike;
  logic [VMEM_W-1:0] w_vmem_next;
  logic [WIDTH-1:0]  w_pkt;
  logic              w_unused;

  assign w_src    = bus.in_data[33:30];
  assign w_type   = bus.in_data[25:24];
  assign w_psum   = bus.in_data[PSUM_W-1:0];
  assign w_unused = ^{bus.in_data[29:26], bus.in_data[23:PSUM_W]};

  assign w_pe_hit = {w_src == PE3_ADDR, w_src == PE2_ADDR, w_src == PE1_ADDR};

  // Map the one-hot source match onto a PE index.
  always_comb begin
    w_pe = 2'd0;
    case (w_pe_hit)
      3'b001:  w_pe = 2'd0;
      3'b010:  w_pe = 2'd1;
      3'b100:  w_pe = 2'd2;
      default: w_pe = 2'd0;
    endcase
  end

  assign w_legal  = (w_type == 2'b10) && (w_pe_hit != 3'b000);
  assign w_row    = r_rcnt[w_pe];
  // A PE that already contributed to its target row is a full window ahead.
  assign w_stall  = w_legal && r_mask[w_row][w_pe];
  assign w_in_ready = !rst && !w_stall;
  assign w_xfer   = bus.in_valid && w_in_ready;
  assign w_accept = w_xfer && w_legal;

  assign w_full     = (r_mask[r_fire_ptr] == 3'b111);
  assign w_last_row = (r_fire_ptr == RW'(OUT_ROWS - 1));
  assign w_last_ts  = (r_ts == TW'(TIMESTEPS - 1));

  assign w_sum       = {1'b0, r_vmem[r_fire_ptr]} + (VMEM_W + 1)'(r_acc[r_fire_ptr]);
  assign w_sat       = w_sum[VMEM_W] ? {VMEM_W{1'b1}} : w_sum[VMEM_W-1:0];
  assign w_spike     = (w_sat >= THR);
  assign w_vmem_next = w_spike ? (w_sat - THR) : w_sat;
  assign w_pkt       = {MY_ADDR, DEST_ADDR, 2'b11, r_ts, 8'(r_fire_ptr), 7'd0, w_spike};

  // Psum accumulation, row firing FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_ROWS; i++) begin
        r_vmem[i] <= '0;
        r_acc[i]  <= '0;
        r_mask[i] <= '0;
      end
      for (int p = 0; p < 3; p++) begin
        r_rcnt[p] <= '0;
      end
      r_fire_ptr  <= '0;
      r_ts        <= '0;
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ts_done   <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_err_drop <= w_xfer && !w_legal;
      r_ts_done  <= 1'b0;

      // The row being cleared in UPDATE is fully masked, so no accept can hit it.
      for (int i = 0; i < OUT_ROWS; i++) begin
        if (r_state == S_UPDATE && RW'(i) == r_fire_ptr) begin
          r_acc[i]  <= '0;
          r_mask[i] <= '0;
        end else if (w_accept && RW'(i) == w_row) begin
          r_acc[i]       <= r_acc[i] + 10'(w_psum);
          r_mask[i][w_pe] <= 1'b1;
        end
      end

      if (w_accept) begin
        r_rcnt[w_pe] <= (w_row == RW'(OUT_ROWS - 1)) ? '0 : w_row + RW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_full) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_vmem[r_fire_ptr] <= w_vmem_next;
          r_out_data         <= w_pkt;
          r_out_valid        <= 1'b1;
          r_state            <= S_SEND;
        end
        S_SEND: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (w_last_row) begin
              r_fire_ptr <= '0;
              r_ts_done  <= 1'b1;
              if (w_last_ts) begin
                r_ts <= '0;
                for (int i = 0; i < OUT_ROWS; i++) begin
                  r_vmem[i] <= '0;
                end
              end else begin
                r_ts <= r_ts + TW'(1);
              end
            end else begin
              r_fire_ptr <= r_fire_ptr + RW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.timestep_done = r_ts_done;
  assign bus.err_drop      = r_err_drop;

endmodule
